mem_port_arbiter: RTL

Arbitrates the processor's single unified memory port between the fetch stage and the memory stage of the five-stage RISC-V pipeline. Issues one transaction at a time to a variable-latency memory over a req/ack handshake, returns read data and a one-cycle acknowledge to the winning requester, and drives the stall outputs the pipeline uses to freeze fetch and memory stages. Data accesses have priority, and a bounded-streak rule prevents fetch starvation.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_streak_cnt.sv | 39 +++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   gnt_src_e   : which requester wins the port this cycle
//   MAX_STREAK_DEFAULT : default bound on consecutive data grants while fetch waits
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } gnt_src_e;

  localparam int unsigned MAX_STREAK_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_streak_cnt.sv
// Saturating count of consecutive data grants issued while fetch is requesting.
//   clk, rst : clock, synchronous active-low reset
//   grant_d  : data grant issued this cycle
//   grant_i  : fetch grant issued this cycle
//   if_req   : fetch request level (a data grant without it breaks the streak)
//   at_max   : streak has reached MAX, fetch must win the next contested grant
module mem_arb_streak_cnt #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_d,
  input  logic grant_i,
  input  logic if_req,
  output logic at_max
);

  localparam int unsigned   CW      = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (grant_i) begin
      r_cnt <= '0;
    end else if (grant_d) begin
      if (!if_req) begin
        r_cnt <= '0;
      end else if (r_cnt != MAX_CNT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign at_max = (r_cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between fetch and the memory stage.
// One transaction in flight; data wins contested grants unless the streak
// counter has reached MAX_STREAK while fetch waits.
//   clk, rst                         : clock, synchronous active-low reset
//   if_req/if_addr -> if_rdata/if_ack : fetch requester (level req, 1-cycle ack)
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack : data requester
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ack : memory handshake
//   stall_if, stall_mem              : pipeline freeze, combinational
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MAX_STREAK = MAX_STREAK_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_if,
  output logic          stall_mem
);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  gnt_src_e      w_gnt;
  logic          w_elig_i;
  logic          w_elig_d;
  logic          w_at_max;

  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_if_ack;
  logic          r_d_ack;

  // A requester still holds req during its ack cycle; masking with the ack
  // keeps that drop cycle from being mistaken for a fresh request.
  assign w_elig_i = if_req & ~r_if_ack;
  assign w_elig_d = d_req & ~r_d_ack;

  mem_arb_streak_cnt #(
    .MAX (MAX_STREAK)
  ) u_streak (
    .clk     (clk),
    .rst     (rst),
    .grant_d (w_gnt == GNT_D),
    .grant_i (w_gnt == GNT_IF),
    .if_req  (if_req),
    .at_max  (w_at_max)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = GNT_NONE;
    case (r_state)
      IDLE: begin
        if (w_elig_d && !(w_elig_i && w_at_max)) begin
          w_gnt       = GNT_D;
          w_state_nxt = BUSY_D;
        end else if (w_elig_i) begin
          w_gnt       = GNT_IF;
          w_state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (w_gnt)
        GNT_D: begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= d_we;
          r_mem_addr  <= d_addr;
          r_mem_wdata <= d_wdata;
        end
        GNT_IF: begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= if_addr;
          r_mem_wdata <= '0;
        end
        default: begin
          if (mem_ack && (r_state == BUSY_I)) begin
            r_mem_req  <= 1'b0;
            r_if_rdata <= mem_rdata;
            r_if_ack   <= 1'b1;
          end else if (mem_ack && (r_state == BUSY_D)) begin
            r_mem_req  <= 1'b0;
            r_d_rdata  <= mem_rdata;
            r_d_ack    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_ack    = r_if_ack;
  assign d_rdata   = r_d_rdata;
  assign d_ack     = r_d_ack;
  assign stall_if  = if_req & ~r_if_ack;
  assign stall_mem = d_req & ~r_d_ack;

endmodule
